// File: rtl/evac_pkg.sv
// Shared widths, dispatch FSM states and the round-robin helper for the
// evacuation dispatch scheduler.
package evac_pkg;

   localparam int ZONE_W = 8;
   localparam int PRIO_W = 2;

   typedef enum logic [1:0] {
      DISP_IDLE  = 2'd0,
      DISP_POP   = 2'd1,
      DISP_OFFER = 2'd2
   } disp_state_t;

   // Next round-robin start position after index idx, wrapping modulo n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/evac_prio_rr_arbiter.sv
// Combinational max-priority pick with round-robin tie-break; owns the
// round-robin pointer, which advances past the winner on each grant strobe.
module evac_prio_rr_arbiter
   import evac_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                          i_clk,
   input  logic                          i_srst,
   input  logic                          i_grant,
   input  logic [N_REQ-1:0]              i_valid,
   input  logic [PRIO_W*N_REQ-1:0]       i_prio,
   output logic                          o_any,
   output logic [$clog2(N_REQ)-1:0]      o_winner
);

   localparam int PTR_W = $clog2(N_REQ);

   logic [PTR_W-1:0]  r_rr_ptr;
   logic [PRIO_W-1:0] w_prio [N_REQ];
   logic [PRIO_W-1:0] w_max;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_prio[gi] = i_prio[gi*PRIO_W +: PRIO_W];
      end
   endgenerate

   always_comb begin
      w_max = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i_valid[i] && (w_prio[i] > w_max)) begin
            w_max = w_prio[i];
         end
      end
   end

   // Scan from the pointer, wrapping, and take the first port at the maximum.
   always_comb begin
      int v_idx;
      o_any    = 1'b0;
      o_winner = '0;
      v_idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         v_idx = (int'(r_rr_ptr) + k) % N_REQ;
         if (!o_any && i_valid[v_idx] && (w_prio[v_idx] == w_max)) begin
            o_any    = 1'b1;
            o_winner = PTR_W'(v_idx);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_rr_ptr <= '0;
      end else if (i_grant) begin
         r_rr_ptr <= PTR_W'(rr_next(int'(o_winner), N_REQ));
      end
   end

endmodule

// File: rtl/evac_dispatch_scheduler.sv
// Admits zone requests into the external evacuation FIFO without overflowing
// it, and pops one record per free rescue team onto a valid/ack interface.
module evac_dispatch_scheduler
   import evac_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int QDEPTH = 4
) (
   input  logic                           Main_Clock,
   input  logic                           Reset,
   input  logic                           Flush,
   input  logic [N_REQ-1:0]               Req_Valid,
   input  logic [ZONE_W*N_REQ-1:0]        Req_Zone,
   input  logic [PRIO_W*N_REQ-1:0]        Req_Priority,
   output logic [N_REQ-1:0]               Req_Ack,
   output logic                           Q_Insert,
   output logic                           Q_Serve,
   output logic                           Q_Clear,
   output logic [ZONE_W-1:0]              Q_Zone,
   output logic [PRIO_W-1:0]              Q_Priority,
   input  logic [ZONE_W-1:0]              Q_Output_Zone,
   input  logic [PRIO_W-1:0]              Q_Output_Priority,
   input  logic                           Q_Empty,
   input  logic                           Team_Ready,
   output logic                           Dispatch_Valid,
   output logic [ZONE_W-1:0]              Dispatch_Zone,
   output logic [PRIO_W-1:0]              Dispatch_Priority,
   input  logic                           Dispatch_Ack,
   output logic [$clog2(QDEPTH+1)-1:0]    Occupancy,
   output logic                           Full
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int OCC_W = $clog2(QDEPTH+1);

   logic              w_any;
   logic [PTR_W-1:0]  w_winner;
   logic              w_admit_ok;
   logic              w_grant;
   logic              w_arb_srst;
   logic [OCC_W-1:0]  w_occ_next;

   disp_state_t       r_state;
   disp_state_t       w_state_next;
   logic              w_serve_next;
   logic              w_valid_next;
   logic              w_latch;

   logic              r_q_insert;
   logic              r_q_serve;
   logic              r_q_clear;
   logic [ZONE_W-1:0] r_q_zone;
   logic [PRIO_W-1:0] r_q_prio;
   logic              r_disp_valid;
   logic [ZONE_W-1:0] r_disp_zone;
   logic [PRIO_W-1:0] r_disp_prio;
   logic [OCC_W-1:0]  r_occ;
   logic              r_full;

   assign w_arb_srst = Reset | Flush;

   evac_prio_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .i_clk    (Main_Clock),
      .i_srst   (w_arb_srst),
      .i_grant  (w_grant),
      .i_valid  (Req_Valid),
      .i_prio   (Req_Priority),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   // A pop in flight this cycle frees a slot, so a full queue can still admit.
   assign w_admit_ok = !Reset && !Flush && ((r_occ < OCC_W'(QDEPTH)) || r_q_serve);
   assign w_grant    = w_any && w_admit_ok;
   assign Req_Ack    = w_grant ? (N_REQ'(1) << w_winner) : '0;
   assign w_occ_next = r_occ + OCC_W'(w_grant) - OCC_W'(r_q_serve);

   always_ff @(posedge Main_Clock) begin
      if (Reset) begin
         r_state <= DISP_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The FIFO still shows pre-clear contents while Q_Clear is high, so wait it out.
   always_comb begin
      w_state_next = r_state;
      if (Flush) begin
         w_state_next = DISP_IDLE;
      end else begin
         case (r_state)
            DISP_IDLE: begin
               if (Team_Ready && !Q_Empty && !r_q_clear) begin
                  w_state_next = DISP_POP;
               end
            end
            DISP_POP:   w_state_next = DISP_OFFER;
            DISP_OFFER: begin
               if (Dispatch_Ack) begin
                  w_state_next = DISP_IDLE;
               end
            end
            default:    w_state_next = DISP_IDLE;
         endcase
      end
   end

   always_comb begin
      w_serve_next = (w_state_next == DISP_POP);
      w_valid_next = (w_state_next == DISP_OFFER);
      w_latch      = (r_state == DISP_POP);
   end

   always_ff @(posedge Main_Clock) begin
      if (Reset || Flush) begin
         r_q_insert   <= 1'b0;
         r_q_serve    <= 1'b0;
         r_q_clear    <= Flush && !Reset;
         r_q_zone     <= '0;
         r_q_prio     <= '0;
         r_disp_valid <= 1'b0;
         r_disp_zone  <= '0;
         r_disp_prio  <= '0;
         r_occ        <= '0;
         r_full       <= 1'b0;
      end else begin
         r_q_clear    <= 1'b0;
         r_q_insert   <= w_grant;
         if (w_grant) begin
            r_q_zone <= Req_Zone[w_winner*ZONE_W +: ZONE_W];
            r_q_prio <= Req_Priority[w_winner*PRIO_W +: PRIO_W];
         end
         r_q_serve    <= w_serve_next;
         r_disp_valid <= w_valid_next;
         if (w_latch) begin
            r_disp_zone <= Q_Output_Zone;
            r_disp_prio <= Q_Output_Priority;
         end
         r_occ        <= w_occ_next;
         r_full       <= (w_occ_next == OCC_W'(QDEPTH));
      end
   end

   assign Q_Insert          = r_q_insert;
   assign Q_Serve           = r_q_serve;
   assign Q_Clear           = r_q_clear;
   assign Q_Zone            = r_q_zone;
   assign Q_Priority        = r_q_prio;
   assign Dispatch_Valid    = r_disp_valid;
   assign Dispatch_Zone     = r_disp_zone;
   assign Dispatch_Priority = r_disp_prio;
   assign Occupancy         = r_occ;
   assign Full              = r_full;

endmodule

// File: tb/tb_evac_dispatch_scheduler.sv
// Directed bench for the evacuation dispatch scheduler with a 4-entry
// order-preserving FIFO model attached to the queue interface.
module tb_evac_dispatch_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [3:0] req_valid = '0;
   logic [31:0] req_zone = '0;
   logic [7:0] req_prio = '0;
   logic [3:0] req_ack;
   logic       q_insert, q_serve, q_clear;
   logic [7:0] q_zone;
   logic [1:0] q_prio;
   logic [7:0] q_out_zone;
   logic [1:0] q_out_prio;
   logic       q_empty;
   logic       team_ready = 1'b0;
   logic       disp_valid;
   logic [7:0] disp_zone;
   logic [1:0] disp_prio;
   logic       disp_ack = 1'b0;
   logic [2:0] occupancy;
   logic       full;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   evac_dispatch_scheduler #(.N_REQ(4), .QDEPTH(4)) dut (
      .Main_Clock        (clk),
      .Reset             (rst),
      .Flush             (flush),
      .Req_Valid         (req_valid),
      .Req_Zone          (req_zone),
      .Req_Priority      (req_prio),
      .Req_Ack           (req_ack),
      .Q_Insert          (q_insert),
      .Q_Serve           (q_serve),
      .Q_Clear           (q_clear),
      .Q_Zone            (q_zone),
      .Q_Priority        (q_prio),
      .Q_Output_Zone     (q_out_zone),
      .Q_Output_Priority (q_out_prio),
      .Q_Empty           (q_empty),
      .Team_Ready        (team_ready),
      .Dispatch_Valid    (disp_valid),
      .Dispatch_Zone     (disp_zone),
      .Dispatch_Priority (disp_prio),
      .Dispatch_Ack      (disp_ack),
      .Occupancy         (occupancy),
      .Full              (full)
   );

   // FIFO model: clear dominates, pop and push may share an edge.
   logic [9:0] fmem [4];
   logic [1:0] fhead = '0;
   logic [1:0] ftail = '0;
   logic [2:0] fcnt  = '0;

   always @(posedge clk) begin
      if (rst || q_clear) begin
         fhead <= '0;
         ftail <= '0;
         fcnt  <= '0;
      end else begin
         if (q_insert) begin
            fmem[ftail] <= {q_zone, q_prio};
            ftail       <= ftail + 2'd1;
         end
         if (q_serve && fcnt != 0) fhead <= fhead + 2'd1;
         fcnt <= fcnt + 3'(q_insert) - 3'(q_serve && fcnt != 0);
      end
   end

   assign q_empty    = (fcnt == 0);
   assign q_out_zone = fmem[fhead][9:2];
   assign q_out_prio = fmem[fhead][1:0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; req_valid = '0; team_ready = 1'b0; disp_ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 4'hF; req_prio = '0;
      #1;
      if (req_ack !== 4'b0000) begin $display("FAIL reset_ack: got %b want 0000", req_ack); errors++; end
      checks++;
      tick();
      if ({q_insert, q_serve, q_clear, disp_valid, full, occupancy} !== 8'h00) begin
         $display("FAIL reset_outputs: got ins=%b srv=%b clr=%b dv=%b full=%b occ=%0d want all 0",
                  q_insert, q_serve, q_clear, disp_valid, full, occupancy); errors++;
      end
      checks++;
      rst = 1'b0; req_valid = '0;
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      req_zone[23:16] = 8'h15; req_prio[5:4] = 2'd1; req_valid = 4'b0100;
      team_ready = 1'b1; disp_ack = 1'b1;
      #1;
      if (req_ack !== 4'b0100) begin $display("FAIL single_ack: got %b want 0100", req_ack); errors++; end
      checks++;
      tick(); req_valid = '0;
      if (q_insert !== 1'b1) begin $display("FAIL single_insert: got %b want 1", q_insert); errors++; end
      checks++;
      if ({q_zone, q_prio} !== {8'h15, 2'd1}) begin $display("FAIL single_qdata: got %h/%0d want 15/1", q_zone, q_prio); errors++; end
      checks++;
      if (occupancy !== 3'd1) begin $display("FAIL single_occ1: got %0d want 1", occupancy); errors++; end
      checks++;
      tick();
      if ({q_insert, q_serve} !== 2'b00) begin $display("FAIL single_c2: got ins=%b srv=%b want 0 0", q_insert, q_serve); errors++; end
      checks++;
      tick();
      if (q_serve !== 1'b1) begin $display("FAIL single_serve: got %b want 1", q_serve); errors++; end
      checks++;
      tick();
      if ({disp_valid, disp_zone, disp_prio} !== {1'b1, 8'h15, 2'd1}) begin
         $display("FAIL single_dispatch: got v=%b %h/%0d want 1 15/1", disp_valid, disp_zone, disp_prio); errors++;
      end
      checks++;
      if (occupancy !== 3'd0) begin $display("FAIL single_occ0: got %0d want 0", occupancy); errors++; end
      checks++;
      tick();
      if (disp_valid !== 1'b0) begin $display("FAIL single_drop: got %b want 0", disp_valid); errors++; end
      checks++;
      disp_ack = 1'b0; team_ready = 1'b0;
      $display("test_single done");
   endtask

   task automatic test_prio_rr();
      do_reset();
      req_zone = {8'h33, 8'h32, 8'h31, 8'h30};
      req_prio = 8'b11_00_11_10;
      req_valid = 4'b1011;
      #1;
      if (req_ack !== 4'b0010) begin $display("FAIL rr_first: got %b want 0010", req_ack); errors++; end
      checks++;
      tick(); req_valid = 4'b1001; #1;
      if (req_ack !== 4'b1000) begin $display("FAIL rr_second: got %b want 1000", req_ack); errors++; end
      checks++;
      tick(); req_valid = 4'b0001; #1;
      if (req_ack !== 4'b0001) begin $display("FAIL rr_third: got %b want 0001", req_ack); errors++; end
      checks++;
      tick(); req_valid = '0;
      if (occupancy !== 3'd3) begin $display("FAIL rr_occ: got %0d want 3", occupancy); errors++; end
      checks++;
      if ({q_insert, q_zone, q_prio} !== {1'b1, 8'h30, 2'd2}) begin
         $display("FAIL rr_qdata: got ins=%b %h/%0d want 1 30/2", q_insert, q_zone, q_prio); errors++;
      end
      checks++;
      flush = 1'b1;
      tick(); flush = 1'b0;
      if ({q_clear, occupancy} !== {1'b1, 3'd0}) begin
         $display("FAIL rr_flush: got clr=%b occ=%0d want 1 0", q_clear, occupancy); errors++;
      end
      checks++;
      req_valid = 4'b0010; #1;
      if (req_ack !== 4'b0010) begin $display("FAIL rr_setup: got %b want 0010", req_ack); errors++; end
      checks++;
      tick(); req_valid = 4'b1010; #1;
      if (req_ack !== 4'b1000) begin $display("FAIL rr_repeat_first: got %b want 1000", req_ack); errors++; end
      checks++;
      tick(); req_valid = 4'b0010; #1;
      if (req_ack !== 4'b0010) begin $display("FAIL rr_repeat_second: got %b want 0010", req_ack); errors++; end
      checks++;
      tick(); req_valid = '0;
      $display("test_prio_rr done");
   endtask

   task automatic test_overflow();
      int acks = 0;
      int ins = 0;
      int extra = 0;
      logic [3:0] a;
      do_reset();
      req_zone = {8'h23, 8'h22, 8'h21, 8'h20};
      req_prio = '0;
      req_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         a = req_ack;
         if (a != 0) acks++;
         if (q_insert) ins++;
         tick();
         for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
               if (extra < 2) begin
                  req_zone[i*8 +: 8] = 8'h24 + 8'(extra);
                  extra++;
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
      #1;
      if (acks != 4) begin $display("FAIL ovf_acks: got %0d want 4", acks); errors++; end
      checks++;
      if (ins != 4) begin $display("FAIL ovf_inserts: got %0d want 4", ins); errors++; end
      checks++;
      if ({full, occupancy} !== {1'b1, 3'd4}) begin $display("FAIL ovf_full: got full=%b occ=%0d want 1 4", full, occupancy); errors++; end
      checks++;
      if ({q_serve, req_ack} !== 5'b0_0000) begin $display("FAIL ovf_wait: got srv=%b ack=%b want 0 0000", q_serve, req_ack); errors++; end
      checks++;
      team_ready = 1'b1;
      tick();
      if ({q_serve, req_ack} !== 5'b1_0001) begin $display("FAIL ovf_resume: got srv=%b ack=%b want 1 0001", q_serve, req_ack); errors++; end
      checks++;
      tick(); req_valid[0] = 1'b0; team_ready = 1'b0; #1;
      if (occupancy !== 3'd4) begin $display("FAIL ovf_net0: got %0d want 4", occupancy); errors++; end
      checks++;
      if ({disp_valid, disp_zone} !== {1'b1, 8'h20}) begin $display("FAIL ovf_order: got v=%b z=%h want 1 20", disp_valid, disp_zone); errors++; end
      checks++;
      if ({q_insert, q_zone, req_ack} !== {1'b1, 8'h24, 4'b0000}) begin
         $display("FAIL ovf_after: got ins=%b z=%h ack=%b want 1 24 0000", q_insert, q_zone, req_ack); errors++;
      end
      checks++;
      req_valid = '0;
      $display("test_overflow done");
   endtask

   task automatic test_backpressure();
      int n = 0;
      do_reset();
      team_ready = 1'b1; disp_ack = 1'b0;
      req_zone[7:0] = 8'h3A; req_prio[1:0] = 2'd2;
      req_zone[15:8] = 8'h3B; req_prio[3:2] = 2'd1;
      req_valid = 4'b0011;
      tick(); req_valid = 4'b0010;
      tick(); req_valid = 4'b0000;
      while (!disp_valid && n < 10) begin tick(); n++; end
      if (disp_valid !== 1'b1) begin $display("FAIL bp_wait: got %b want 1 within 10 cycles", disp_valid); errors++; end
      checks++;
      for (int c = 0; c < 10; c++) begin
         if ({disp_valid, disp_zone, disp_prio, q_serve} !== {1'b1, 8'h3A, 2'd2, 1'b0}) begin
            $display("FAIL bp_hold%0d: got v=%b %h/%0d srv=%b want 1 3a/2 0", c, disp_valid, disp_zone, disp_prio, q_serve); errors++;
         end
         checks++;
         tick();
      end
      disp_ack = 1'b1;
      tick();
      if (disp_valid !== 1'b0) begin $display("FAIL bp_drop: got %b want 0", disp_valid); errors++; end
      checks++;
      tick();
      if (q_serve !== 1'b1) begin $display("FAIL bp_next_pop: got %b want 1", q_serve); errors++; end
      checks++;
      tick();
      if ({disp_valid, disp_zone, disp_prio} !== {1'b1, 8'h3B, 2'd1}) begin
         $display("FAIL bp_next_rec: got v=%b %h/%0d want 1 3b/1", disp_valid, disp_zone, disp_prio); errors++;
      end
      checks++;
      disp_ack = 1'b0; team_ready = 1'b0;
      $display("test_backpressure done");
   endtask

   task automatic test_flush_mid_offer();
      int n = 0;
      logic [3:0] a;
      do_reset();
      team_ready = 1'b1; disp_ack = 1'b0;
      req_zone = {8'h43, 8'h42, 8'h41, 8'h40};
      req_prio = '0;
      req_valid = 4'hF;
      for (int c = 0; c < 4; c++) begin
         #1; a = req_ack;
         tick(); req_valid = req_valid & ~a;
      end
      while (!disp_valid && n < 10) begin tick(); n++; end
      if ({disp_valid, disp_zone, occupancy} !== {1'b1, 8'h40, 3'd3}) begin
         $display("FAIL fl_pre: got v=%b z=%h occ=%0d want 1 40 3", disp_valid, disp_zone, occupancy); errors++;
      end
      checks++;
      flush = 1'b1;
      tick(); flush = 1'b0;
      if ({q_clear, disp_valid, occupancy, q_serve} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
         $display("FAIL fl_after: got clr=%b v=%b occ=%0d srv=%b want 1 0 0 0", q_clear, disp_valid, occupancy, q_serve); errors++;
      end
      checks++;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (q_serve !== 1'b0) begin $display("FAIL fl_noserve%0d: got %b want 0", c, q_serve); errors++; end
         checks++;
      end
      req_zone[23:16] = 8'h44; req_valid = 4'b0100; #1;
      if (req_ack !== 4'b0100) begin $display("FAIL fl_newack: got %b want 0100", req_ack); errors++; end
      checks++;
      tick(); req_valid = '0;
      n = 0;
      while (!disp_valid && n < 8) begin tick(); n++; end
      if ({disp_valid, disp_zone} !== {1'b1, 8'h44}) begin $display("FAIL fl_newrec: got v=%b z=%h want 1 44", disp_valid, disp_zone); errors++; end
      checks++;
      team_ready = 1'b0;
      $display("test_flush_mid_offer done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      team_ready = 1'b1; disp_ack = 1'b0;
      req_zone = {8'h53, 8'h52, 8'h51, 8'h50};
      req_prio = '0;
      req_valid = 4'b0001;
      tick(); req_valid = '0;
      tick();
      tick();
      if (q_serve !== 1'b1) begin $display("FAIL rm_pop: got %b want 1", q_serve); errors++; end
      checks++;
      rst = 1'b1; req_valid = 4'b1000; #1;
      if (req_ack !== 4'b0000) begin $display("FAIL rm_ack: got %b want 0000", req_ack); errors++; end
      checks++;
      tick(); rst = 1'b0;
      if ({q_insert, q_serve, q_clear, q_zone, q_prio, disp_valid, disp_zone, disp_prio, occupancy, full} !== 27'd0) begin
         $display("FAIL rm_zero: got ins=%b srv=%b clr=%b qz=%h dv=%b dz=%h occ=%0d full=%b want all 0",
                  q_insert, q_serve, q_clear, q_zone, disp_valid, disp_zone, occupancy, full); errors++;
      end
      checks++;
      req_valid = 4'b1001; #1;
      if (req_ack !== 4'b0001) begin $display("FAIL rm_rrptr: got %b want 0001", req_ack); errors++; end
      checks++;
      tick(); req_valid = '0;
      if ({q_serve, q_insert, q_zone} !== {1'b0, 1'b1, 8'h50}) begin
         $display("FAIL rm_idle: got srv=%b ins=%b z=%h want 0 1 50", q_serve, q_insert, q_zone); errors++;
      end
      checks++;
      team_ready = 1'b0;
      $display("test_reset_mid done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_prio_rr();
      test_overflow();
      test_backpressure();
      test_flush_mid_offer();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
